mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter W, default `WORD_WIDTH (32), data/address width.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, number of lost arbitrations after which fetch is forced to win (range 1..15).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on posedge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports if_req input 1, if_addr input W, if_done output 1, instruction fetch requester.
REQ-006 SHALL have ports ld_req input 1, ld_addr input W, ld_done output 1, load requester.
REQ-007 SHALL have ports st_req input 1, st_addr input W, st_data input W, st_done output 1, store requester.
REQ-008 SHALL have port rd_data  output  W  registered read data, valid while if_done or ld_done is high.
REQ-009 SHALL have ports mem_read_en output 1, mem_write_en output 1, mem_addr output W, mem_wdata output W, mem_rdata input W, single-port memory side.
REQ-010 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-011 SHALL implement FSM states IDLE, ACCESS, RESP; IDLE->ACCESS when any req is high, ACCESS->RESP unconditionally, RESP->IDLE unconditionally.
REQ-012 SHALL arbitrate only in IDLE, with fixed priority st > ld > if, except REQ-014.
REQ-013 SHALL latch winner id, address and store data in the IDLE->ACCESS cycle; later changes on requester inputs SHALL NOT affect the transaction.
REQ-014 SHALL keep a fetch starvation counter: +1 per IDLE arbitration where if_req is high and fetch loses; when counter equals STARVE_LIMIT and if_req is high, fetch wins regardless of priority; counter clears when fetch is granted; counter saturates at STARVE_LIMIT.
REQ-015 SHALL, in ACCESS, drive mem_addr with latched address and exactly one of mem_read_en (fetch/load) or mem_write_en (store) high for exactly one cycle; mem_wdata = latched store data.
REQ-016 SHALL, in RESP, register mem_rdata into rd_data (reads only) and assert the winner's done for exactly one cycle; rd_data SHALL be valid in that same cycle.
REQ-017 SHALL deassert all memory enables in IDLE and RESP; mem_addr/mem_wdata are don't-care when enables are low.
REQ-018 Latency: req high in IDLE at cycle N -> done high at cycle N+2; back-to-back throughput one access per 3 cycles.
REQ-019 Requesters SHALL hold req and operands until their done; req still high in the IDLE cycle after done is treated as a new request.
REQ-020 Simultaneous requests SHALL be served one at a time; losers wait with no done and no side effect.
REQ-021 At most one of if_done, ld_done, st_done SHALL be high in any cycle.
REQ-022 rd_data SHALL hold its last value outside read RESP cycles.

Reset
REQ-023 rst high at a posedge SHALL force state IDLE, starvation counter 0, rd_data 0, all done outputs 0, mem_read_en 0, mem_write_en 0, busy 0.
REQ-024 Reset during ACCESS or RESP SHALL abort the transaction: no done issued, no memory enable in the following cycle.

Structure
REQ-025 FSM state encoding and requester-id constants SHALL live in the shared defines.v; W SHALL default from `WORD_WIDTH there.
REQ-026 The priority/starvation selection SHALL be a sub-module mem_arb_select (combinational pick plus counter), instantiated once.

Verification
REQ-027 Single load: ld_req, ld_addr=0x40, memory holds 0xDEADBEEF -> mem_read_en at N+1 with mem_addr=0x40, ld_done and rd_data=0xDEADBEEF at N+2.
REQ-028 All three requests in one cycle -> order store, load, fetch; dones at N+2, N+5, N+8; one memory enable per access.
REQ-029 Store 0x12345678 to 0x80 then fetch from 0x80 -> mem_write_en with mem_wdata=0x12345678, then fetch rd_data=0x12345678.
REQ-030 if_req and ld_req held continuously with STARVE_LIMIT=4 -> 4 load grants, then fetch grant, counter back to 0.
REQ-031 rst asserted in the ACCESS cycle of a load -> no ld_done, enables low next cycle, busy 0, FSM in IDLE.
REQ-032 Change ld_addr from 0x40 to 0x44 during ACCESS -> memory still sees 0x40.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared FSM states, requester ids and default word width
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
package mem_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
  typedef enum logic [1:0] {ID_IF, ID_LD, ID_ST} req_id_e;
endpackage

// File: rtl/mem_arb_select.sv
// mem_arb_select: fixed-priority pick (st > ld > if) with fetch starvation override
module mem_arb_select
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    arb_i,
  input  logic    if_req_i,
  input  logic    ld_req_i,
  input  logic    st_req_i,
  output req_id_e grant_o
);
  logic [3:0] cnt_q, cnt_d;
  logic       starved;
  assign starved = if_req_i && cnt_q == 4'(STARVE_LIMIT);
  always_comb begin
    grant_o = starved ? ID_IF : st_req_i ? ID_ST : ld_req_i ? ID_LD : ID_IF;
    cnt_d   = !arb_i ? cnt_q :
              grant_o == ID_IF ? '0 :
              (if_req_i && cnt_q < 4'(STARVE_LIMIT)) ? cnt_q + 4'd1 : cnt_q;
  end
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises fetch/load/store onto a single-port memory, one access per 3 cycles
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int W            = `WORD_WIDTH,
  parameter int STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         if_req,
  input  logic [W-1:0] if_addr,
  output logic         if_done,
  input  logic         ld_req,
  input  logic [W-1:0] ld_addr,
  output logic         ld_done,
  input  logic         st_req,
  input  logic [W-1:0] st_addr,
  input  logic [W-1:0] st_data,
  output logic         st_done,
  output logic [W-1:0] rd_data,
  output logic         mem_read_en,
  output logic         mem_write_en,
  output logic [W-1:0] mem_addr,
  output logic [W-1:0] mem_wdata,
  input  logic [W-1:0] mem_rdata,
  output logic         busy
);
  state_e       state_q, state_d;
  req_id_e      id_q, id_d, grant;
  logic [W-1:0] addr_q, addr_d, wdata_q, wdata_d, rd_q, rd_d;
  logic         take;
  assign take = state_q == IDLE && (if_req || ld_req || st_req);
  mem_arb_select #(.STARVE_LIMIT(STARVE_LIMIT)) u_sel (
    .clk      (clk),
    .rst      (rst),
    .arb_i    (take),
    .if_req_i (if_req),
    .ld_req_i (ld_req),
    .st_req_i (st_req),
    .grant_o  (grant)
  );
  // operands are captured only on the IDLE->ACCESS edge so requesters cannot disturb an access
  always_comb begin
    state_d = state_q == IDLE ? (take ? ACCESS : IDLE) : state_q == ACCESS ? RESP : IDLE;
    id_d    = take ? grant : id_q;
    addr_d  = !take ? addr_q : grant == ID_ST ? st_addr : grant == ID_LD ? ld_addr : if_addr;
    wdata_d = take ? st_data : wdata_q;
    rd_d    = (state_q == ACCESS && id_q != ID_ST) ? mem_rdata : rd_q;
  end
  always_ff @(posedge clk) begin
    state_q <= rst ? IDLE : state_d;
    id_q    <= rst ? ID_IF : id_d;
    rd_q    <= rst ? '0 : rd_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end
  assign mem_read_en  = state_q == ACCESS && id_q != ID_ST;
  assign mem_write_en = state_q == ACCESS && id_q == ID_ST;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign if_done      = state_q == RESP && id_q == ID_IF;
  assign ld_done      = state_q == RESP && id_q == ID_LD;
  assign st_done      = state_q == RESP && id_q == ID_ST;
  assign rd_data      = rd_q;
  assign busy         = state_q != IDLE;
endmodule
